// File: rtl/fb_write_arbiter_if.sv
// Write-side bus of the frame-buffer arbiter: two pixel requesters,
// clear control/status and the registered BRAM write port.
interface fb_write_arbiter_if;
  logic        clear_start;
  logic        clear_busy;
  logic        clear_done;
  logic        req0;
  logic        req1;
  logic [9:0]  x0;
  logic [9:0]  x1;
  logic [8:0]  y0;
  logic [8:0]  y1;
  logic        d0;
  logic        d1;
  logic        ack0;
  logic        ack1;
  logic        oob_err;
  logic        bram_we;
  logic [18:0] bram_addr;
  logic        bram_din;

  // Arbiter side
  modport slave (
    input  clear_start, req0, req1, x0, x1, y0, y1, d0, d1,
    output clear_busy, clear_done, ack0, ack1, oob_err,
           bram_we, bram_addr, bram_din
  );

  // Requester / controller side
  modport master (
    output clear_start, req0, req1, x0, x1, y0, y1, d0, d1,
    input  clear_busy, clear_done, ack0, ack1, oob_err,
           bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port controller: round-robin arbitration between two
// pixel writers plus a full-frame clear engine. Drives only the BRAM write port.
module fb_write_arbiter #(
  parameter int unsigned WIDTH     = 640,
  parameter int unsigned HEIGHT    = 480,
  parameter logic        CLEAR_VAL = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  fb_write_arbiter_if.slave    bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

  state_t     state, state_nxt;
  logic       last;
  logic       sweep_end;
  logic [9:0] cx;
  logic [8:0] cy;

  logic       hs;
  logic [9:0] sel_x;
  logic [8:0] sel_y;
  logic       sel_d;
  logic       in_range;
  logic       cnt_last;
  logic       clear_write;

  assign bus.clear_busy = (state == CLEAR);

  assign hs       = bus.ack0 | bus.ack1;
  assign sel_x    = bus.ack1 ? bus.x1 : bus.x0;
  assign sel_y    = bus.ack1 ? bus.y1 : bus.y0;
  assign sel_d    = bus.ack1 ? bus.d1 : bus.d0;
  assign in_range = (sel_x <= X_LAST) && (sel_y <= Y_LAST);
  assign cnt_last = (cx == X_LAST) && (cy == Y_LAST);

  // The first clear write is issued on the very edge that accepts clear_start,
  // so sweep_end marks that the final pixel went out and the next CLEAR cycle
  // only retires the sweep.
  assign clear_write = ((state == IDLE) && bus.clear_start) ||
                       ((state == CLEAR) && !sweep_end);

  // Next-state and combinational grants
  always_comb begin
    state_nxt = state;
    bus.ack0  = 1'b0;
    bus.ack1  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clear_start) begin
          state_nxt = CLEAR;
        end else if (bus.req0 && bus.req1) begin
          bus.ack0 = last;
          bus.ack1 = ~last;
        end else begin
          bus.ack0 = bus.req0;
          bus.ack1 = bus.req1;
        end
      end
      CLEAR: begin
        if (sweep_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Registered write port, round-robin pointer and clear counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last           <= 1'b1;
      sweep_end      <= 1'b0;
      cx             <= '0;
      cy             <= '0;
      bus.bram_we    <= 1'b0;
      bus.bram_addr  <= '0;
      bus.bram_din   <= 1'b0;
      bus.clear_done <= 1'b0;
      bus.oob_err    <= 1'b0;
    end else begin
      bus.bram_we    <= 1'b0;
      bus.clear_done <= 1'b0;
      bus.oob_err    <= 1'b0;
      if (clear_write) begin
        bus.bram_we   <= 1'b1;
        bus.bram_addr <= {cy, cx};
        bus.bram_din  <= CLEAR_VAL;
        sweep_end     <= cnt_last;
        if (cnt_last) begin
          cx <= '0;
          cy <= '0;
        end else if (cx == X_LAST) begin
          cx <= '0;
          cy <= cy + 9'd1;
        end else begin
          cx <= cx + 10'd1;
        end
      end else if (state == CLEAR) begin
        sweep_end      <= 1'b0;
        bus.clear_done <= 1'b1;
      end else if (hs) begin
        last <= bus.ack1;
        if (in_range) begin
          bus.bram_we   <= 1'b1;
          bus.bram_addr <= {sel_y, sel_x};
          bus.bram_din  <= sel_d;
        end else begin
          bus.oob_err   <= 1'b1;
        end
      end
    end
  end

endmodule
